instr_fetch_unit: RTL and testbench

- Requester side of the instruction-memory interface.
- Owns the program counter and generates the memory address and a one-cycle read strobe.
- Captures the returned 16-bit instruction and presents it to the datapath through a valid/ready handshake.
- On a conditional jump it stalls until the datapath reports the zero-test result, then redirects the PC relative to the jump's own address.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Requester side of the instruction-memory interface. Owns the
//            program counter, issues a one-cycle read strobe per fetch,
//            captures the returned instruction and hands it to the datapath
//            over a valid/ready handshake. Conditional jumps (jump-if-zero)
//            stall the unit until the datapath reports the zero-test result,
//            then the PC is redirected relative to the jump's own address.
//
// Ports    : clk          system clock, rising edge
//            rst          synchronous active-high reset
//            start        pulse, honoured only in IDLE
//            start_addr   first instruction address
//            end_addr     address of the last instruction to issue
//            im_addr      instruction memory address (= PC)
//            im_rd        one-cycle read strobe to instruction memory
//            im_instr     instruction data from memory
//            instr_out    captured instruction
//            instr_pc     address of instr_out
//            instr_valid  instr_out valid
//            instr_ready  datapath accepts instr_out
//            br_valid     jump-resolution pulse from datapath
//            br_zero      1 = tested register was zero (jump taken)
//            busy         high in any state except IDLE
//            done         one-cycle pulse after the end_addr instruction
//
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int         ADDR_W     = 16,
    parameter int         INSTR_W    = 16,
    parameter logic [3:0] JMP_OPCODE = 4'b0101,
    parameter int         OFF_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  end_addr,
    output logic [ADDR_W-1:0]  im_addr,
    output logic               im_rd,
    input  logic [INSTR_W-1:0] im_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_valid,
    input  logic               br_zero,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAITM   = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT_BR = 3'd4;

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_capture;
    logic               w_is_jmp;
    logic [ADDR_W-1:0]  w_off_sext;
    logic               w_at_end;

    assign w_is_jmp   = (r_instr[INSTR_W-1 -: 4] == JMP_OPCODE);
    // Offset is two's complement; sign-extension makes backward jumps and
    // wrap-around fall out of plain modulo-2^ADDR_W addition.
    assign w_off_sext = {{(ADDR_W-OFF_W){r_instr[OFF_W-1]}}, r_instr[OFF_W-1:0]};
    assign w_at_end   = (r_pc == end_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = start_addr;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAITM;
            end
            S_WAITM: begin
                // Memory latched the address on the edge ending REQ, so its
                // data is stable for the whole of this cycle.
                w_capture   = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (w_is_jmp) begin
                        // End-of-program check waits until the jump resolves:
                        // a taken jump must keep executing.
                        w_state_nxt = S_WAIT_BR;
                    end else if (w_at_end) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pc_nxt    = r_pc + c_pc_one;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_WAIT_BR: begin
                if (br_valid) begin
                    if (br_zero) begin
                        w_pc_nxt    = r_pc + w_off_sext;
                        w_state_nxt = S_REQ;
                    end else if (w_at_end) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pc_nxt    = r_pc + c_pc_one;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_instr    <= im_instr;
                r_instr_pc <= r_pc;
            end
        end
    end

    // REQ lasts exactly one cycle and is always followed by WAITM, so a
    // state-decoded strobe can never be high in two consecutive cycles.
    assign im_rd       = (r_state == S_REQ);
    assign im_addr     = r_pc;
    assign instr_out   = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. Stimulus pushes the
//            hand-computed fetch addresses, accepted (pc, instr) pairs and
//            jump answers into queues; a monitor pops and compares them as
//            the DUT strobes im_rd or completes a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic [15:0] im_addr;
    logic        im_rd;
    logic [15:0] im_instr;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic        br_zero;
    logic        busy;
    logic        done;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .im_addr     (im_addr),
        .im_rd       (im_rd),
        .im_instr    (im_instr),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_zero     (br_zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Instruction memory: latches the address on the im_rd edge.
    logic [15:0] mem [0:65535];
    logic [15:0] mem_q = 16'h0000;
    always @(posedge clk) if (im_rd) mem_q <= mem[im_addr];
    assign im_instr = mem_q;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [15:0] fetch_q [$];
    acc_t        acc_q   [$];
    bit          br_q    [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // ---------------- monitor ----------------
    logic prev_rd = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                if (im_rd) begin
                    chk("im_rd_single_cycle", {31'd0, prev_rd}, 32'd0);
                    if (fetch_q.size() == 0)
                        fail_now($sformatf("unexpected_fetch: im_addr=%0h, no fetch expected", im_addr));
                    else
                        chk("im_addr", {16'd0, im_addr}, {16'd0, fetch_q.pop_front()});
                end
                if (instr_valid && instr_ready) begin
                    if (acc_q.size() == 0) begin
                        fail_now($sformatf("unexpected_accept: pc=%0h instr=%0h", instr_pc, instr_out));
                    end else begin
                        acc_t e;
                        e = acc_q.pop_front();
                        chk("instr_pc", {16'd0, instr_pc}, {16'd0, e.pc});
                        chk("instr_out", {16'd0, instr_out}, {16'd0, e.instr});
                    end
                end
                if (done) done_cnt++;
                prev_rd = im_rd;
            end
        end
    end

    // ---------------- jump responder ----------------
    initial begin
        br_valid = 1'b0;
        br_zero  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready && instr_out[15:12] == 4'h5) begin
                @(posedge clk);
                #1;
                if (br_q.size() == 0) begin
                    fail_now("br_answer_missing");
                end else begin
                    br_zero  = br_q.pop_front();
                    br_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    br_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a);
        fetch_q.push_back(a);
        acc_q.push_back('{pc: a, instr: mem[a]});
    endtask

    task automatic go(input logic [15:0] sa, input logic [15:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!instr_valid) fail_now("wait_valid_timeout");
    endtask

    task automatic wait_idle(input int exp_done);
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        if (busy) fail_now("wait_idle_timeout");
        tick();
        tick();
        chk("done_count", done_cnt, exp_done);
        chk("fetch_q_drained", fetch_q.size(), 0);
        chk("acc_q_drained", acc_q.size(), 0);
        done_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; instr_ready = 1'b1;
        mem[0]  = 16'h1111; mem[1]  = 16'h2222; mem[2]  = 16'h3333; mem[3]  = 16'h4444;
        mem[4]  = 16'h1004; mem[5]  = 16'h5303; mem[8]  = 16'h1008; mem[9]  = 16'h1009;
        mem[16] = 16'h1010; mem[17] = 16'h1011; mem[18] = 16'h1012; mem[19] = 16'h55FD;
        mem[20] = 16'h1014; mem[32] = 16'h1020; mem[33] = 16'h5002;
        mem[40] = 16'h1028; mem[41] = 16'h1029; mem[48] = 16'h1030;
        mem[16'hFFFF] = 16'h1FFF;
        tick(); tick(); tick();

        // Reset state
        chk("rst_im_addr", {16'd0, im_addr}, 32'd0);
        chk("rst_im_rd", {31'd0, im_rd}, 32'd0);
        chk("rst_instr_out", {16'd0, instr_out}, 32'd0);
        chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line 0..3
        for (int a = 0; a < 4; a++) push(16'(a));
        go(16'd0, 16'd3);
        chk("im_rd_in_req", {31'd0, im_rd}, 32'd1);
        chk("busy_running", {31'd0, busy}, 32'd1);
        n = 0;
        while (!instr_valid && n < 10) begin
            tick();
            n++;
        end
        chk("fetch_latency", n, 2);
        wait_idle(1);

        // Taken forward jump: 4 -> 5 (jmp +3) -> 8 -> 9
        push(16'd4); push(16'd5); push(16'd8); push(16'd9);
        br_q.push_back(1'b1);
        go(16'd4, 16'd9);
        wait_idle(1);

        // Backward loop: 16..19 taken three times (-3), then falls through to 20
        for (int k = 0; k < 4; k++)
            for (int a = 16; a < 20; a++) push(16'(a));
        push(16'd20);
        br_q.push_back(1'b1); br_q.push_back(1'b1); br_q.push_back(1'b1); br_q.push_back(1'b0);
        go(16'd16, 16'd20);
        wait_idle(1);

        // Not-taken jump at end_addr: done, no further fetch
        push(16'd32); push(16'd33);
        br_q.push_back(1'b0);
        go(16'd32, 16'd33);
        wait_idle(1);
        for (int k = 0; k < 5; k++) tick();
        chk("no_fetch_after_done", fetch_q.size(), 0);

        // Backpressure plus ignored start while busy
        instr_ready = 1'b0;
        push(16'd40); push(16'd41);
        go(16'd40, 16'd41);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr_out", {16'd0, instr_out}, 32'h1028);
            chk("bp_instr_pc", {16'd0, instr_pc}, 32'd40);
            chk("bp_im_rd", {31'd0, im_rd}, 32'd0);
            if (k == 2) begin
                start_addr = 16'd0;
                start      = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_accept_first_ready", {31'd0, instr_valid}, 32'd0);
        wait_idle(1);

        // Reset mid-ISSUE, then a wrapping run from 0xFFFF to 0x0000
        instr_ready = 1'b0;
        fetch_q.push_back(16'd48);
        go(16'd48, 16'd50);
        wait_valid();
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_im_rd", {31'd0, im_rd}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_im_addr", {16'd0, im_addr}, 32'd0);
        rst = 1'b0;
        instr_ready = 1'b1;
        tick();
        push(16'hFFFF); push(16'h0000);
        go(16'hFFFF, 16'h0000);
        wait_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
